// File: rtl/blocpu_pkg.sv
// blocpu_pkg: definitions shared by the blocpu core and its program runner.
//   INSTR_W / ADDR_W / CYC_W : default instruction, address and cycle-counter widths
//   state_t                  : program-runner FSM state encoding
//   ld_open()                : states in which the runner accepts load words
package blocpu_pkg;

  localparam int INSTR_W = 12;
  localparam int ADDR_W  = 8;
  localparam int CYC_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ARMED = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  // DONE and FAULT accept words too: a word there starts a fresh program.
  function automatic logic ld_open(input state_t s);
    return (s == ST_IDLE) || (s == ST_LOAD) || (s == ST_DONE) || (s == ST_FAULT);
  endfunction

endpackage

// File: rtl/blocpu_program_runner_if.sv
// blocpu_program_runner_if: program-load channel into the runner plus the
// instruction-memory write bus that the runner drives toward the core.
//   ld_valid/ld_ready/ld_data/ld_last : load channel (host -> runner)
//   imem_we/imem_addr/imem_wdata      : instruction-memory write (runner -> core)
// Handshake: a word transfers on every rising clk edge where ld_valid and
// ld_ready are both high; ld_data and ld_last must be stable while ld_valid is
// high, and the host must not make ld_valid depend on ld_ready.
interface blocpu_program_runner_if #(
  parameter int INSTR_W = blocpu_pkg::INSTR_W,
  parameter int ADDR_W  = blocpu_pkg::ADDR_W
);
  logic               ld_valid;
  logic               ld_ready;
  logic [INSTR_W-1:0] ld_data;
  logic               ld_last;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;

  modport master (
    output ld_valid, ld_data, ld_last,
    input  ld_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  ld_valid, ld_data, ld_last,
    output ld_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/blocpu_cycle_counter.sv
// blocpu_cycle_counter: run-cycle counter with saturation and limit compare.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : zero the count (wins over en)
//   en        : count this cycle
//   limit     : cycle limit, 0 = unlimited
//   count     : registered count, saturates at all-ones
//   limit_hit : the cycle now counting is the limit-th one (count+1 == limit)
module blocpu_cycle_counter #(
  parameter int CYC_W = blocpu_pkg::CYC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CYC_W-1:0] limit,
  output logic [CYC_W-1:0] count,
  output logic             limit_hit
);

  logic [CYC_W-1:0] count_q, count_d;
  logic [CYC_W:0]   count_inc;

  // One bit wider so a saturated count never aliases onto a small limit.
  assign count_inc = {1'b0, count_q} + (CYC_W+1)'(1);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_inc[CYC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign limit_hit = (limit != '0) && (count_inc == {1'b0, limit});

endmodule

// File: rtl/blocpu_program_runner.sv
// blocpu_program_runner: loads a program into the blocpu instruction memory,
// then runs the core until it halts, hits a cycle limit, or is aborted.
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : load channel in, instruction-memory write strobe out
//   start, abort  : run control
//   cycle_limit   : maximum run cycles, 0 = unlimited
//   core_run      : core enable
//   core_halted   : core has executed halt (level)
//   busy          : loading or running
//   done / timed_out / overflow : completion status
//   prog_len      : number of words loaded
//   cycles        : cycles spent running
//   dbg_state     : current FSM state
module blocpu_program_runner #(
  parameter int INSTR_W = blocpu_pkg::INSTR_W,
  parameter int ADDR_W  = blocpu_pkg::ADDR_W,
  parameter int CYC_W   = blocpu_pkg::CYC_W
) (
  input  logic                  clk,
  input  logic                  rst,
  blocpu_program_runner_if.slave bus,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CYC_W-1:0]      cycle_limit,
  output logic                  core_run,
  input  logic                  core_halted,
  output logic                  busy,
  output logic                  done,
  output logic                  timed_out,
  output logic                  overflow,
  output logic [ADDR_W:0]       prog_len,
  output logic [CYC_W-1:0]      cycles,
  output blocpu_pkg::state_t    dbg_state
);
  import blocpu_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t          state_q, state_d;
  logic [ADDR_W:0] prog_len_q, prog_len_d;
  logic            ld_ready_q, ld_ready_d;
  logic            core_run_q, core_run_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            timed_out_q, timed_out_d;
  logic            overflow_q, overflow_d;

  logic              fresh_load;
  logic              accept;
  logic [ADDR_W-1:0] wr_addr;
  logic              cnt_clr;
  logic              limit_hit;

  // A word taken in IDLE, DONE or FAULT starts a new program at address 0.
  assign fresh_load = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_FAULT);
  // Abort beats a word offered in the same LOAD cycle; nothing is written in reset.
  assign accept  = bus.ld_valid && ld_ready_q && !rst && !(abort && (state_q == ST_LOAD));
  assign wr_addr = fresh_load ? '0 : prog_len_q[ADDR_W-1:0];

  assign bus.ld_ready   = ld_ready_q;
  assign bus.imem_we    = accept;
  assign bus.imem_addr  = accept ? wr_addr : '0;
  assign bus.imem_wdata = accept ? bus.ld_data : '0;

  blocpu_cycle_counter #(.CYC_W(CYC_W)) u_cycle_counter (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .en        (core_run_q),
    .limit     (cycle_limit),
    .count     (cycles),
    .limit_hit (limit_hit)
  );

  always_comb begin
    state_d     = state_q;
    prog_len_d  = prog_len_q;
    done_d      = done_q;
    timed_out_d = timed_out_q;
    overflow_d  = overflow_q;
    cnt_clr     = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (accept) begin
          prog_len_d  = (ADDR_W+1)'(1);
          done_d      = 1'b0;
          timed_out_d = 1'b0;
          overflow_d  = 1'b0;
          cnt_clr     = 1'b1;
          state_d     = bus.ld_last ? ST_ARMED : ST_LOAD;
        end else if (start && (state_q != ST_IDLE) && (prog_len_q != '0) && !overflow_q) begin
          // Re-run of the program already held in instruction memory.
          done_d      = 1'b0;
          timed_out_d = 1'b0;
          cnt_clr     = 1'b1;
          state_d     = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          prog_len_d = prog_len_q + (ADDR_W+1)'(1);
          if (bus.ld_last) begin
            state_d = ST_ARMED;
          end else if (wr_addr == LAST_ADDR) begin
            // Memory is full and the program still has not ended.
            overflow_d = 1'b1;
            state_d    = ST_FAULT;
          end
        end
      end
      ST_ARMED: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (core_halted) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (limit_hit) begin
          timed_out_d = 1'b1;
          state_d     = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    core_run_d = (state_d == ST_RUN);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_RUN);
    ld_ready_d = ld_open(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prog_len_q  <= '0;
      ld_ready_q  <= 1'b0;
      core_run_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prog_len_q  <= prog_len_d;
      ld_ready_q  <= ld_ready_d;
      core_run_q  <= core_run_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timed_out_q <= timed_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign core_run  = core_run_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timed_out = timed_out_q;
  assign overflow  = overflow_q;
  assign prog_len  = prog_len_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_blocpu_program_runner.sv
// tb_blocpu_program_runner: directed bench for blocpu_program_runner.
// Two instances: u_dut with the default 8-bit address and u_small with a
// 2-bit address for the memory-overflow case. Expected instruction-memory
// writes go into per-instance queues and are popped by a negedge monitor.
module tb_blocpu_program_runner;
  import blocpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        start, abort, core_halted;
  logic [15:0] cycle_limit;
  logic        core_run, busy, done, timed_out, overflow;
  logic [8:0]  prog_len;
  logic [15:0] cycles;
  state_t      m_state;

  logic        s_start, s_abort, s_halted;
  logic [15:0] s_limit;
  logic        s_core_run, s_busy, s_done, s_timed_out, s_overflow;
  logic [2:0]  s_prog_len;
  logic [15:0] s_cycles;
  state_t      s_state;

  blocpu_program_runner_if #(.INSTR_W(12), .ADDR_W(8)) m_bus ();
  blocpu_program_runner_if #(.INSTR_W(12), .ADDR_W(2)) s_bus ();

  blocpu_program_runner #(.INSTR_W(12), .ADDR_W(8), .CYC_W(16)) u_dut (
    .clk(clk), .rst(rst), .bus(m_bus), .start(start), .abort(abort),
    .cycle_limit(cycle_limit), .core_run(core_run), .core_halted(core_halted),
    .busy(busy), .done(done), .timed_out(timed_out), .overflow(overflow),
    .prog_len(prog_len), .cycles(cycles), .dbg_state(m_state)
  );

  blocpu_program_runner #(.INSTR_W(12), .ADDR_W(2), .CYC_W(16)) u_small (
    .clk(clk), .rst(rst), .bus(s_bus), .start(s_start), .abort(s_abort),
    .cycle_limit(s_limit), .core_run(s_core_run), .core_halted(s_halted),
    .busy(s_busy), .done(s_done), .timed_out(s_timed_out), .overflow(s_overflow),
    .prog_len(s_prog_len), .cycles(s_cycles), .dbg_state(s_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  int run_cnt = 0;
  int run_base;
  logic [19:0] exp_q[$];
  logic [13:0] exp_s_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic load_m(input logic [11:0] data, input logic last, input logic [7:0] addr);
    m_bus.ld_valid = 1'b1;
    m_bus.ld_data  = data;
    m_bus.ld_last  = last;
    exp_q.push_back({addr, data});
    tick();
    m_bus.ld_valid = 1'b0;
    m_bus.ld_last  = 1'b0;
  endtask

  task automatic load_s(input logic [11:0] data, input logic last, input logic [1:0] addr);
    s_bus.ld_valid = 1'b1;
    s_bus.ld_data  = data;
    s_bus.ld_last  = last;
    exp_s_q.push_back({addr, data});
    tick();
    s_bus.ld_valid = 1'b0;
    s_bus.ld_last  = 1'b0;
  endtask

  // scoreboard monitor: every write strobe must match the head of its queue
  initial begin
    logic [19:0] e;
    logic [13:0] es;
    forever begin
      @(negedge clk);
      if (core_run) run_cnt++;
      if (m_bus.imem_we) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL imem_main: unexpected write addr=%0h data=%0h", m_bus.imem_addr, m_bus.imem_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({m_bus.imem_addr, m_bus.imem_wdata} !== e) begin
            n_err++;
            $display("FAIL imem_main: got addr=%0h data=%0h, required addr=%0h data=%0h",
                     m_bus.imem_addr, m_bus.imem_wdata, e[19:12], e[11:0]);
          end
        end
      end
      if (s_bus.imem_we) begin
        n_cmp++;
        if (exp_s_q.size() == 0) begin
          n_err++;
          $display("FAIL imem_small: unexpected write addr=%0h data=%0h", s_bus.imem_addr, s_bus.imem_wdata);
        end else begin
          es = exp_s_q.pop_front();
          if ({s_bus.imem_addr, s_bus.imem_wdata} !== es) begin
            n_err++;
            $display("FAIL imem_small: got addr=%0h data=%0h, required addr=%0h data=%0h",
                     s_bus.imem_addr, s_bus.imem_wdata, es[13:12], es[11:0]);
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [11:0] prog [8];
    prog = '{12'h100, 12'h700, 12'hF00, 12'hC00, 12'h901, 12'h50A, 12'h301, 12'hF13};

    rst = 1'b1; start = 1'b0; abort = 1'b0; core_halted = 1'b0; cycle_limit = '0;
    m_bus.ld_valid = 1'b0; m_bus.ld_data = '0; m_bus.ld_last = 1'b0;
    s_start = 1'b0; s_abort = 1'b0; s_halted = 1'b0; s_limit = '0;
    s_bus.ld_valid = 1'b0; s_bus.ld_data = '0; s_bus.ld_last = 1'b0;
    repeat (3) tick();

    // reset state
    check("rst_state", 32'(m_state), 32'(ST_IDLE));
    check("rst_ld_ready", 32'(m_bus.ld_ready), 0);
    check("rst_status", {busy, done, timed_out, overflow, core_run}, 0);
    check("rst_prog_len", 32'(prog_len), 0);
    check("rst_cycles", 32'(cycles), 0);
    rst = 1'b0;
    check("ld_ready_before_edge", 32'(m_bus.ld_ready), 0);
    tick();
    check("ld_ready_after_rst", 32'(m_bus.ld_ready), 1);

    // load 8-word program
    for (int i = 0; i < 8; i++) load_m(prog[i], (i == 7), 8'(i));
    check("load_prog_len", 32'(prog_len), 8);
    check("load_state", 32'(m_state), 32'(ST_ARMED));
    check("armed_ld_ready", 32'(m_bus.ld_ready), 0);
    check("armed_busy", 32'(busy), 0);

    // run, halt during cycle 20
    run_base = run_cnt;
    start = 1'b1; tick(); start = 1'b0;
    check("run_core_run", 32'(core_run), 1);
    check("run_busy", 32'(busy), 1);
    repeat (19) tick();
    core_halted = 1'b1; tick(); core_halted = 1'b0;
    check("halt_state", 32'(m_state), 32'(ST_DONE));
    check("halt_done", 32'(done), 1);
    check("halt_cycles", 32'(cycles), 20);
    check("halt_busy", 32'(busy), 0);
    check("halt_core_run", 32'(core_run), 0);
    check("halt_run_len", 32'(run_cnt - run_base), 20);
    check("done_ld_ready", 32'(m_bus.ld_ready), 1);

    // re-run with cycle_limit=5, core never halts
    cycle_limit = 16'd5;
    run_base = run_cnt;
    start = 1'b1; tick(); start = 1'b0;
    check("rerun_cycles_clr", 32'(cycles), 0);
    check("rerun_done_clr", 32'(done), 0);
    repeat (4) tick();
    check("limit_pre_core_run", 32'(core_run), 1);
    tick();
    check("limit_state", 32'(m_state), 32'(ST_FAULT));
    check("limit_timed_out", 32'(timed_out), 1);
    check("limit_cycles", 32'(cycles), 5);
    check("limit_core_run", 32'(core_run), 0);
    check("limit_run_len", 32'(run_cnt - run_base), 5);
    check("limit_overflow", 32'(overflow), 0);

    // re-run from FAULT, abort during cycle 3
    cycle_limit = '0;
    start = 1'b1; tick(); start = 1'b0;
    check("fault_rerun_state", 32'(m_state), 32'(ST_RUN));
    check("fault_rerun_timed_out", 32'(timed_out), 0);
    tick(); tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_state", 32'(m_state), 32'(ST_IDLE));
    check("abort_core_run", 32'(core_run), 0);
    check("abort_done", 32'(done), 0);
    check("abort_timed_out", 32'(timed_out), 0);
    check("abort_prog_len", 32'(prog_len), 8);
    check("abort_cycles", 32'(cycles), 3);

    // reload 3 words, run to halt, then re-run from DONE
    load_m(12'h123, 1'b0, 8'd0);
    load_m(12'h456, 1'b0, 8'd1);
    load_m(12'hABC, 1'b1, 8'd2);
    check("reload_prog_len", 32'(prog_len), 3);
    check("reload_cycles", 32'(cycles), 0);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    core_halted = 1'b1; tick(); core_halted = 1'b0;
    check("short_done", 32'(done), 1);
    check("short_cycles", 32'(cycles), 2);
    start = 1'b1; tick(); start = 1'b0;
    check("done_rerun_state", 32'(m_state), 32'(ST_RUN));
    check("done_rerun_cycles", 32'(cycles), 0);
    core_halted = 1'b1; tick(); core_halted = 1'b0;
    check("done_rerun_cycles_end", 32'(cycles), 1);

    // reset during LOAD after 3 words
    load_m(12'h111, 1'b0, 8'd0);
    load_m(12'h222, 1'b0, 8'd1);
    load_m(12'h333, 1'b0, 8'd2);
    check("midload_state", 32'(m_state), 32'(ST_LOAD));
    check("midload_busy", 32'(busy), 1);
    rst = 1'b1; tick();
    check("midrst_prog_len", 32'(prog_len), 0);
    check("midrst_status", {busy, done, timed_out, overflow, core_run, m_bus.ld_ready}, 0);
    check("midrst_cycles", 32'(cycles), 0);
    rst = 1'b0; tick();
    load_m(12'h777, 1'b1, 8'd0);
    check("postrst_prog_len", 32'(prog_len), 1);
    check("postrst_state", 32'(m_state), 32'(ST_ARMED));

    // reset during RUN drops core_run
    start = 1'b1; tick(); start = 1'b0;
    check("prerst_core_run", 32'(core_run), 1);
    rst = 1'b1; tick();
    check("runrst_core_run", 32'(core_run), 0);
    check("runrst_state", 32'(m_state), 32'(ST_IDLE));
    rst = 1'b0; tick();

    // small instance: overflow on the 4th word of a 4-word memory
    for (int i = 0; i < 4; i++) load_s(12'hA00 + 12'(i), 1'b0, 2'(i));
    check("ovf_overflow", 32'(s_overflow), 1);
    check("ovf_state", 32'(s_state), 32'(ST_FAULT));
    check("ovf_ld_ready", 32'(s_bus.ld_ready), 1);
    check("ovf_prog_len", 32'(s_prog_len), 4);
    s_start = 1'b1; tick(); s_start = 1'b0;
    check("ovf_start_ignored", 32'(s_state), 32'(ST_FAULT));
    check("ovf_start_core_run", 32'(s_core_run), 0);
    load_s(12'h5A5, 1'b0, 2'd0);
    check("ovf_newload_state", 32'(s_state), 32'(ST_LOAD));
    check("ovf_newload_overflow", 32'(s_overflow), 0);
    check("ovf_newload_prog_len", 32'(s_prog_len), 1);

    tick();
    check("main_queue_drained", 32'(exp_q.size()), 0);
    check("small_queue_drained", 32'(exp_s_q.size()), 0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
